// File: rtl/encoder_pkg.sv
// Shared encoder definitions: FSM state type, safe clog2 helper and the
// index code reported for an all-zero vector.
package encoder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Index presented whenever no request bit is set.
  localparam int IDX_ZERO = 0;

  // Ceiling log2 that never returns less than 1, so a W-bit bus always exists.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational MSB-first priority encoder: idx is the highest set bit of
// vec (IDX_ZERO when vec is empty) and any flags a non-empty vector.
module prio_enc_comb
  import encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_safe(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the MSB wins.
  always_comb begin
    idx = W'(IDX_ZERO);
    any = |vec;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_serializer.sv
// Captures an N-bit request vector and serialises it as one encoded index
// per accepted beat, highest set bit first.
// Optional build macro: ZERO_SUPPRESS_EN -- when defined, an all-zero vector
// is swallowed in IDLE without producing an output beat.
module prio_encoder_serializer
  import encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int W = clog2_safe(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_idx,
  output logic         out_zero,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_t       state_r, state_s;
  logic [N-1:0] pend_r, pend_s;
  logic [N-1:0] clr_mask_s, pend_clr_s, src_s;
  logic [W-1:0] enc_idx_s, idx_s;
  logic         enc_any_s, single_s, capture_s;
  logic         zero_s, last_s, valid_s, ready_s;

  // The bit currently on out_idx is removed from pend when its beat is accepted.
  assign clr_mask_s = ONE_N << out_idx;
  assign pend_clr_s = pend_r & ~clr_mask_s;

  // In IDLE the first beat comes straight from req; in DRAIN from what remains.
  assign src_s    = (state_r == IDLE) ? req : pend_clr_s;
  // At most one bit left (also true for an empty vector) marks the final beat.
  assign single_s = ((src_s & (src_s - ONE_N)) == {N{1'b0}});

`ifdef ZERO_SUPPRESS_EN
  assign capture_s = in_valid & enc_any_s;
`else
  assign capture_s = in_valid;
`endif

  prio_enc_comb #(.N(N), .W(W)) u_enc (
    .vec (src_s),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    idx_s   = out_idx;
    zero_s  = out_zero;
    last_s  = out_last;
    valid_s = out_valid;
    ready_s = in_ready;
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          state_s = DRAIN;
          pend_s  = req;
          idx_s   = enc_idx_s;
          zero_s  = ~enc_any_s;
          last_s  = single_s;
          valid_s = 1'b1;
          ready_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (out_ready && out_last) begin
          state_s = IDLE;
          pend_s  = {N{1'b0}};
          idx_s   = W'(IDX_ZERO);
          zero_s  = 1'b0;
          last_s  = 1'b0;
          valid_s = 1'b0;
          ready_s = 1'b1;
        end else if (out_ready) begin
          pend_s  = pend_clr_s;
          idx_s   = enc_idx_s;
          zero_s  = 1'b0;
          last_s  = single_s;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
        pend_s  = {N{1'b0}};
        idx_s   = W'(IDX_ZERO);
        zero_s  = 1'b0;
        last_s  = 1'b0;
        valid_s = 1'b0;
        ready_s = 1'b1;
      end
    endcase
  end

  // State, pending vector and output registers; reset discards any pending beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pend_r    <= {N{1'b0}};
      out_idx   <= W'(IDX_ZERO);
      out_zero  <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= state_s;
      pend_r    <= pend_s;
      out_idx   <= idx_s;
      out_zero  <= zero_s;
      out_last  <= last_s;
      out_valid <= valid_s;
      in_ready  <= ready_s;
    end
  end

endmodule
